mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mips_mem_pkg.sv | 12 +
 rtl/mem_timeout_ctr.sv | 23 ++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared defaults and FSM state encoding for the fetch/data memory port arbiter.
package mips_mem_pkg;
  localparam int AW_DEFAULT         = 30;
  localparam int MAX_STREAK_DEFAULT = 3;
  localparam int TIMEOUT_DEFAULT    = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts serve cycles without mem_ready.
// Expired flags the cycle in which the count would reach TIMEOUT.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = enable && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one single-port memory.
// Data wins unless it has already taken MAX_STREAK grants while fetch waited.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW         = AW_DEFAULT,
  parameter int MAX_STREAK = MAX_STREAK_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_valid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [31:0]   d_rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  input  logic [31:0]   mem_rdata
);
  localparam int SW = $clog2(MAX_STREAK + 1);

  state_t        state, state_nxt;
  logic [SW-1:0] streak;
  logic [AW-1:0] lat_addr;
  logic          lat_we;
  logic [31:0]   lat_wdata;
  logic          serving, expired;

  assign serving = (state == SERVE_I) || (state == SERVE_D);

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (i_gnt || d_gnt),
    .enable  (serving && !mem_ready),
    .expired (expired)
  );

  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || streak < SW'(MAX_STREAK))) begin
          d_gnt     = 1'b1;
          state_nxt = SERVE_D;
        end else if (i_req) begin
          i_gnt     = 1'b1;
          state_nxt = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: if (mem_ready || expired) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state   <= state_nxt;
      i_valid <= (state == SERVE_I) && (mem_ready || expired);
      d_valid <= (state == SERVE_D) && (mem_ready || expired);
      // expired already excludes mem_ready, so a same-cycle ready wins
      err     <= expired;
      if (d_gnt) begin
        lat_addr  <= d_addr;
        lat_we    <= d_we;
        lat_wdata <= d_wdata;
        if (!i_req)                         streak <= '0;
        else if (streak != SW'(MAX_STREAK)) streak <= streak + 1'b1;
      end else if (i_gnt) begin
        lat_addr <= i_addr;
        lat_we   <= 1'b0;
        streak   <= '0;
      end
      if (state == SERVE_I) begin
        if (mem_ready)    i_rdata <= mem_rdata;
        else if (expired) i_rdata <= '0;
      end
      if (state == SERVE_D) begin
        if (mem_ready && !lat_we) d_rdata <= mem_rdata;
        else if (expired)         d_rdata <= '0;
      end
    end
  end

  assign mem_req   = serving;
  assign mem_we    = (state == SERVE_D) && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW  = 30;
  localparam int MS  = 3;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we, mem_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [31:0]   d_wdata, mem_rdata;
  logic          i_gnt, i_valid, d_gnt, d_valid, err, mem_req, mem_we;
  logic [31:0]   i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int n_chk  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.AW(AW), .MAX_STREAK(MS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask

  // One data read completing in its first serve cycle; ends in the valid cycle.
  task automatic d_read(input logic [AW-1:0] a, input logic [31:0] dat);
    d_req = 1; d_we = 0; d_addr = a;
    @(negedge clk); d_req = 0; mem_ready = 1; mem_rdata = dat;
    @(negedge clk); mem_ready = 0; #1;
    n_chk++; if ({d_valid, d_rdata} !== {1'b1, dat}) begin
      n_fail++; $display("FAIL d_read: got %h want %h", {d_valid, d_rdata}, {1'b1, dat});
    end
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); #1;
    n_chk++; if ({i_gnt, d_gnt, i_valid, d_valid, err, mem_req, mem_we, i_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_state: outputs not all zero during reset");
    end
    @(negedge clk); @(negedge clk); rst = 0; #1;
    n_chk++; if ({i_gnt, d_gnt, i_valid, d_valid, err, mem_req, mem_we, i_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_release: outputs not all zero after release");
    end
  endtask

  task automatic test_lone_fetch();
    do_reset();
    i_req = 1; i_addr = 30'h4; #1;
    n_chk++; if ({i_gnt, d_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL lone_gnt: got %b want 10", {i_gnt, d_gnt});
    end
    @(negedge clk); i_req = 0; mem_ready = 1; mem_rdata = 32'h200a0005; #1;
    n_chk++; if ({mem_req, mem_we, mem_addr, i_valid} !== {1'b1, 1'b0, 30'h4, 1'b0}) begin
      n_fail++; $display("FAIL lone_cmd: got %h want %h", {mem_req, mem_we, mem_addr, i_valid}, {1'b1, 1'b0, 30'h4, 1'b0});
    end
    @(negedge clk); mem_ready = 0; #1;
    n_chk++; if ({i_valid, err, mem_req, i_rdata} !== {1'b1, 1'b0, 1'b0, 32'h200a0005}) begin
      n_fail++; $display("FAIL lone_valid: got %h want %h", {i_valid, err, mem_req, i_rdata}, {1'b1, 1'b0, 1'b0, 32'h200a0005});
    end
    @(negedge clk); #1;
    n_chk++; if (i_valid !== 1'b0) begin
      n_fail++; $display("FAIL lone_pulse: i_valid got %b want 0", i_valid);
    end
  endtask

  task automatic test_simultaneous();
    bit seq[$];
    do_reset();
    i_req = 1; d_req = 1; d_we = 0; i_addr = 30'h3; d_addr = 30'h5; mem_ready = 1;
    for (int c = 0; c < 16; c++) begin
      #1;
      n_chk++; if (i_gnt && d_gnt) begin
        n_fail++; $display("FAIL sim_excl: both grants at cycle %0d", c);
      end
      if (i_gnt) seq.push_back(1'b1);
      else if (d_gnt) seq.push_back(1'b0);
      @(negedge clk);
    end
    idle_inputs();
    n_chk++; if (seq.size() != 8) begin
      n_fail++; $display("FAIL sim_count: got %0d grants want 8", seq.size());
    end
    for (int k = 0; k < seq.size(); k++) begin
      n_chk++; if (seq[k] !== ((k % 4) == 3)) begin
        n_fail++; $display("FAIL sim_order: grant %0d got i=%b want i=%b", k, seq[k], (k % 4) == 3);
      end
    end
  endtask

  task automatic test_data_write();
    do_reset();
    d_read(30'h7, 32'hdeadbeef);
    d_req = 1; d_we = 1; d_addr = 30'h2; d_wdata = 32'h0000000c; #1;
    n_chk++; if ({i_gnt, d_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL wr_gnt: got %b want 01", {i_gnt, d_gnt});
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); d_req = 0; d_we = 0; mem_ready = (k == 4); #1;
      n_chk++; if ({mem_req, mem_we, mem_addr, mem_wdata, d_valid} !== {1'b1, 1'b1, 30'h2, 32'hc, 1'b0}) begin
        n_fail++; $display("FAIL wr_cmd: cycle %0d got %h want %h", k,
          {mem_req, mem_we, mem_addr, mem_wdata, d_valid}, {1'b1, 1'b1, 30'h2, 32'hc, 1'b0});
      end
    end
    @(negedge clk); mem_ready = 0; #1;
    n_chk++; if ({d_valid, err, d_rdata} !== {1'b1, 1'b0, 32'hdeadbeef}) begin
      n_fail++; $display("FAIL wr_done: got %h want %h", {d_valid, err, d_rdata}, {1'b1, 1'b0, 32'hdeadbeef});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    d_read(30'h9, 32'h12345678);
    d_req = 1; d_we = 0; d_addr = 30'h1; #1;
    n_chk++; if (d_gnt !== 1'b1) begin
      n_fail++; $display("FAIL tmo_gnt: d_gnt got %b want 1", d_gnt);
    end
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk); d_req = 0; i_req = 1; i_addr = 30'h8; #1;
      n_chk++; if ({mem_req, d_valid, err, i_gnt} !== 4'b1000) begin
        n_fail++; $display("FAIL tmo_wait: cycle %0d got %b want 1000", k, {mem_req, d_valid, err, i_gnt});
      end
    end
    @(negedge clk); #1;
    n_chk++; if ({d_valid, err, d_rdata, i_gnt, d_gnt} !== {1'b1, 1'b1, 32'h0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL tmo_abort: got %h want %h", {d_valid, err, d_rdata, i_gnt, d_gnt}, {1'b1, 1'b1, 32'h0, 1'b1, 1'b0});
    end
    @(negedge clk); i_req = 0; #1;
    n_chk++; if ({d_valid, err, mem_req, mem_addr} !== {1'b0, 1'b0, 1'b1, 30'h8}) begin
      n_fail++; $display("FAIL tmo_fetch: got %h want %h", {d_valid, err, mem_req, mem_addr}, {1'b0, 1'b0, 1'b1, 30'h8});
    end
    // ready lands in the very cycle the timeout would fire: normal completion
    for (int k = 2; k <= TMO; k++) begin
      @(negedge clk); mem_ready = (k == TMO); mem_rdata = 32'hcafe0001;
    end
    @(negedge clk); mem_ready = 0; #1;
    n_chk++; if ({i_valid, err, i_rdata} !== {1'b1, 1'b0, 32'hcafe0001}) begin
      n_fail++; $display("FAIL tmo_race: got %h want %h", {i_valid, err, i_rdata}, {1'b1, 1'b0, 32'hcafe0001});
    end
  endtask

  task automatic test_reset_mid_serve();
    do_reset();
    i_req = 1; i_addr = 30'h10;
    @(negedge clk); i_req = 0;
    @(negedge clk); #1;
    n_chk++; if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: mem_req got %b want 1", mem_req);
    end
    rst = 1; #1;
    n_chk++; if ({mem_req, mem_we, i_valid, err} !== 4'b0000) begin
      n_fail++; $display("FAIL rmid_drop: got %b want 0000", {mem_req, mem_we, i_valid, err});
    end
    mem_ready = 1; mem_rdata = 32'h55aa55aa;
    @(negedge clk); @(negedge clk); rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_chk++; if ({i_gnt, d_gnt, i_valid, d_valid, err, mem_req, mem_we, i_rdata, d_rdata} !== '0) begin
        n_fail++; $display("FAIL rmid_quiet: cycle %0d outputs not zero, i_valid=%b i_rdata=%h", k, i_valid, i_rdata);
      end
    end
    mem_ready = 0;
  endtask

  task automatic test_stray_ready();
    do_reset();
    mem_ready = 1; mem_rdata = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_chk++; if ({i_valid, d_valid, err, mem_req, i_rdata, d_rdata} !== '0) begin
        n_fail++; $display("FAIL stray: cycle %0d got %h want 0", k, {i_valid, d_valid, err, mem_req, i_rdata, d_rdata});
      end
    end
    mem_ready = 0; i_req = 1; i_addr = 30'h21; #1;
    n_chk++; if (i_gnt !== 1'b1) begin
      n_fail++; $display("FAIL stray_idle: i_gnt got %b want 1", i_gnt);
    end
    @(negedge clk); i_req = 0;
  endtask

  task automatic test_random();
    bit busy, cur_d, cur_we, hang, ev_i, ev_d, ee, eg_i, eg_d;
    logic [AW-1:0] cur_addr;
    logic [31:0] cur_wdata, er_i, er_d;
    int waitc, streak;
    do_reset();
    busy = 0; cur_d = 0; cur_we = 0; hang = 0; ev_i = 0; ev_d = 0; ee = 0;
    eg_i = 0; eg_d = 0; cur_addr = '0; cur_wdata = '0; er_i = '0; er_d = '0;
    waitc = 0; streak = 0;
    for (int c = 0; c < 3000; c++) begin
      #1;
      n_chk++; if ({i_valid, d_valid, err, i_rdata, d_rdata} !== {ev_i, ev_d, ee, er_i, er_d}) begin
        n_fail++; $display("FAIL rnd_resp: cycle %0d got %h want %h", c,
          {i_valid, d_valid, err, i_rdata, d_rdata}, {ev_i, ev_d, ee, er_i, er_d});
      end
      if (!i_req && $urandom_range(0, 2) == 0) begin i_req = 1; i_addr = AW'($urandom); end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = $urandom_range(0, 1) == 1; d_addr = AW'($urandom); d_wdata = $urandom;
      end
      mem_ready = (busy && hang) ? 1'b0 : ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      #1;
      eg_d = !busy && d_req && (!i_req || streak < MS);
      eg_i = !busy && !eg_d && i_req;
      n_chk++; if ({i_gnt, d_gnt} !== {eg_i, eg_d}) begin
        n_fail++; $display("FAIL rnd_gnt: cycle %0d got %b want %b", c, {i_gnt, d_gnt}, {eg_i, eg_d});
      end
      n_chk++;
      if (busy) begin
        if ({mem_req, mem_we, mem_addr} !== {1'b1, cur_we, cur_addr} || (cur_d && mem_wdata !== cur_wdata)) begin
          n_fail++; $display("FAIL rnd_cmd: cycle %0d got %h/%h want %h/%h", c,
            {mem_req, mem_we, mem_addr}, mem_wdata, {1'b1, cur_we, cur_addr}, cur_wdata);
        end
      end else if ({mem_req, mem_we} !== 2'b00) begin
        n_fail++; $display("FAIL rnd_idle_cmd: cycle %0d got %b want 00", c, {mem_req, mem_we});
      end
      ev_i = 0; ev_d = 0; ee = 0;
      if (busy) begin
        if (mem_ready) begin
          if (cur_d) begin ev_d = 1; if (!cur_we) er_d = mem_rdata; end
          else begin ev_i = 1; er_i = mem_rdata; end
          busy = 0;
        end else begin
          waitc++;
          if (waitc == TMO) begin
            ee = 1; busy = 0;
            if (cur_d) begin ev_d = 1; er_d = '0; end
            else begin ev_i = 1; er_i = '0; end
          end
        end
      end else if (eg_d) begin
        busy = 1; cur_d = 1; cur_we = d_we; cur_addr = d_addr; cur_wdata = d_wdata; waitc = 0;
        streak = i_req ? ((streak < MS) ? streak + 1 : streak) : 0;
        hang = $urandom_range(0, 9) == 0;
      end else if (eg_i) begin
        busy = 1; cur_d = 0; cur_we = 0; cur_addr = i_addr; waitc = 0; streak = 0;
        hang = $urandom_range(0, 9) == 0;
      end
      @(negedge clk);
      if (eg_d) d_req = 0;
      if (eg_i) i_req = 0;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_data_write();
    test_timeout();
    test_reset_mid_serve();
    test_stray_ready();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
